mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
Parametrised load/store unit for the MEM stage of the pipelined RV core, replacing the single-cycle word-only memory controller. It takes one instruction per handshake from EX and supports byte, half, word and (when XLEN=64) double accesses, with sign or zero extension, byte-enable generation and misalignment detection. It drives a req/gnt/rvalid data-memory port that tolerates variable latency, back-pressures EX while an access is outstanding, and registers the result toward WB.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
ADDR_W, 32, data-memory byte-address width.
RA_W, 5, register-file index width.

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid_i  in  1  EX presents an instruction
in_ready_o  out  1  stage can accept; equals (state==IDLE)
ld_i  in  1  load
st_i  in  1  store; ld_i and st_i are never both 1
size_i  in  2  00=B, 01=H, 10=W, 11=D
unsigned_i  in  1  zero-extend the load result
addr_i  in  ADDR_W  effective byte address
wdata_i  in  XLEN  store data (rs2)
alu_res_i  in  XLEN  result for non-memory instructions
rd_i  in  RA_W  destination register
wb_en_i  in  1  instruction writes rd
dmem_req_o  out  1  request valid
dmem_we_o  out  1  1 = write
dmem_be_o  out  XLEN/8  byte enables
dmem_addr_o  out  ADDR_W  address aligned to XLEN/8 bytes (low bits zero)
dmem_wdata_o  out  XLEN  lane-replicated store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  XLEN  read data
wb_valid_o  out  1  one-cycle result pulse to WB
wb_en_o  out  1  register write enable
wb_rd_o  out  RA_W  destination register
wb_data_o  out  XLEN  write-back data
misalign_o  out  1  one-cycle pulse; rides with wb_valid_o

Behaviour:
- Reset: rst is synchronous and active-high. While rst=1, state goes to IDLE and every registered output is cleared to 0: wb_valid_o, wb_en_o, wb_rd_o, wb_data_o, misalign_o, and all dmem_* outputs. Reset mid-access abandons the access. Any dmem_rvalid_i that arrives after reset is ignored.
- FSM states: IDLE, REQ, WAIT.
- Accept: an instruction is taken when in_valid_i && in_ready_o.
- Non-memory op (ld_i=0, st_i=0): stay in IDLE. Next cycle, wb_valid_o=1 with wb_data_o=alu_res_i, wb_en_o=wb_en_i and wb_rd_o=rd_i. Latency is 1 cycle and throughput is 1 per cycle.
- Illegal or misaligned access: H with addr[0]!=0, W with addr[1:0]!=0, D with addr[2:0]!=0, or size=D when XLEN=32. No memory request is issued. Next cycle: wb_valid_o=1, misalign_o=1, wb_en_o=0. State stays IDLE.
- Legal load/store: latch op, size, unsigned flag, address low bits, rd and wb_en, then go to REQ.
- REQ:
  - dmem_req_o=1; dmem_addr_o, dmem_we_o=st, dmem_be_o and dmem_wdata_o are held stable until dmem_gnt_i.
  - Grant is allowed in the first REQ cycle.
  - On a store grant: return to IDLE and pulse wb_valid_o with wb_en_o=0 in the next cycle.
  - On a load grant: go to WAIT.
- WAIT: dmem_req_o=0. On dmem_rvalid_i, extract the addressed lane, extend it, pulse wb_valid_o with wb_en_o=latched wb_en and wb_data_o=result, then return to IDLE. Memory latency is unbounded. dmem_rvalid_i seen in IDLE or REQ is ignored.
- Byte enables: ones of width 2^size, shifted left by addr[log2(XLEN/8)-1:0].
- Store data: the low 2^size bytes of wdata_i, replicated across every lane.
- Load extension: sign-extend from bit 8*2^size-1 unless unsigned_i=1. A W load when XLEN=64 uses the upper or lower half selected by addr[2].
- Minimum latency: store 2 cycles from accept to wb_valid_o; load 3 cycles when gnt arrives in the first REQ cycle and rvalid in the following cycle.
- wb_valid_o is high for exactly one cycle per accepted instruction, and instructions complete in order.

Decomposition:
- Shared package (core_pkg): size encodings SZ_B/SZ_H/SZ_W/SZ_D, LSU FSM state encodings, and the XLEN default.
- One sub-module, lsu_align: combinational logic for byte-enable generation, store-data replication, load lane extraction and extension, and the misalignment check. The parent module holds the FSM and the pipeline registers.

Test Plan:
- Non-memory op: alu_res_i=0x12345678, rd_i=7, wb_en_i=1 -> next cycle wb_valid_o=1, wb_rd_o=7, wb_data_o=0x12345678, no dmem_req_o.
- SB: addr_i=0x103, wdata_i=0xAABBCCDD, gnt in the same cycle as req -> dmem_addr_o=0x100, be=1000, dmem_wdata_o=0xDDDDDDDD, dmem_we_o=1; wb_valid_o with wb_en_o=0 two cycles after accept.
- LB signed vs LBU: addr_i=0x202, dmem_rdata_i=0x0080FF00 -> LB gives 0xFFFFFF80, LBU gives 0x00000080; wb_en_o=1.
- LH at addr 0x006 with gnt delayed 3 cycles and rvalid delayed 5 cycles -> in_ready_o=0 throughout, request fields stable until gnt, dmem_req_o drops after gnt, a single wb_valid_o pulse.
- LW at addr 0x002 -> no dmem_req_o; next cycle misalign_o=1, wb_valid_o=1, wb_en_o=0.
- Reset in WAIT, then a stale dmem_rvalid_i -> all outputs 0 and state IDLE; the stale rvalid produces no wb_valid_o.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline: access-size encodings, LSU FSM states and
// the default datapath width.
package core_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StWait = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: byte enables, store-data replication,
// load lane extraction/extension and the misalignment check.
module lsu_align
  import core_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [2:0]        addr_lo_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [XLEN/8-1:0] be_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              misalign_o
);

  localparam int unsigned BeW  = XLEN / 8;
  localparam int unsigned OffW = $clog2(BeW);

  size_e           w_size;
  logic [OffW-1:0] w_off;
  logic [BeW-1:0]  w_mask;
  logic [XLEN-1:0] w_shifted;

  assign w_size    = size_e'(size_i);
  assign w_off     = addr_lo_i[OffW-1:0];
  assign w_shifted = rdata_i >> {w_off, 3'b000};
  assign be_o      = w_mask << w_off;

  always_comb begin
    w_mask     = '1;
    wdata_o    = wdata_i;
    rdata_o    = w_shifted;
    misalign_o = 1'b0;
    case (w_size)
      SZ_B: begin
        w_mask  = BeW'(1);
        wdata_o = {(XLEN/8){wdata_i[7:0]}};
        rdata_o = unsigned_i ? XLEN'(w_shifted[7:0]) : XLEN'($signed(w_shifted[7:0]));
      end
      SZ_H: begin
        w_mask     = BeW'(3);
        wdata_o    = {(XLEN/16){wdata_i[15:0]}};
        rdata_o    = unsigned_i ? XLEN'(w_shifted[15:0]) : XLEN'($signed(w_shifted[15:0]));
        misalign_o = addr_lo_i[0];
      end
      SZ_W: begin
        w_mask     = BeW'(15);
        wdata_o    = {(XLEN/32){wdata_i[31:0]}};
        rdata_o    = unsigned_i ? XLEN'(w_shifted[31:0]) : XLEN'($signed(w_shifted[31:0]));
        misalign_o = |addr_lo_i[1:0];
      end
      default: begin
        // Double is only legal on a 64-bit datapath
        misalign_o = (XLEN == 32) || (|addr_lo_i);
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: accepts one instruction per handshake from EX, drives a
// req/gnt/rvalid data-memory port and registers a single result pulse toward WB.
module mem_stage_lsu
  import core_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              ld_i,
  input  logic              st_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   alu_res_i,
  input  logic [RA_W-1:0]   rd_i,
  input  logic              wb_en_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              wb_valid_o,
  output logic              wb_en_o,
  output logic [RA_W-1:0]   wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              misalign_o
);

  localparam int unsigned BeW  = XLEN / 8;
  localparam int unsigned OffW = $clog2(BeW);

  lsu_state_e r_state, w_state_d;

  logic            r_is_st, r_uns, r_wb_en;
  logic [1:0]      r_size;
  logic [2:0]      r_off;
  logic [RA_W-1:0] r_rd;

  logic              r_dmem_req, r_dmem_we;
  logic [BeW-1:0]    r_dmem_be;
  logic [ADDR_W-1:0] r_dmem_addr;
  logic [XLEN-1:0]   r_dmem_wdata;
  logic              r_wb_valid, r_wb_en_o, r_misalign;
  logic [RA_W-1:0]   r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;

  logic            w_accept, w_mem, w_idle;
  logic [1:0]      w_al_size;
  logic            w_al_uns;
  logic [2:0]      w_al_off;
  logic [BeW-1:0]  w_be;
  logic [XLEN-1:0] w_wdata, w_rdata;
  logic            w_mis;

  assign w_idle     = (r_state == StIdle);
  assign in_ready_o = w_idle;
  assign w_accept   = in_valid_i & w_idle;
  assign w_mem      = ld_i | st_i;

  // In IDLE the aligner sees the incoming instruction; otherwise the latched one
  assign w_al_size = w_idle ? size_i     : r_size;
  assign w_al_uns  = w_idle ? unsigned_i : r_uns;
  assign w_al_off  = w_idle ? addr_i[2:0] : r_off;

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .size_i    (w_al_size),
    .unsigned_i(w_al_uns),
    .addr_lo_i (w_al_off),
    .wdata_i   (wdata_i),
    .rdata_i   (dmem_rdata_i),
    .be_o      (w_be),
    .wdata_o   (w_wdata),
    .rdata_o   (w_rdata),
    .misalign_o(w_mis)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_accept && w_mem && !w_mis) w_state_d = StReq;
      StReq:   if (dmem_gnt_i) w_state_d = r_is_st ? StIdle : StWait;
      StWait:  if (dmem_rvalid_i) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_st      <= 1'b0;
      r_uns        <= 1'b0;
      r_wb_en      <= 1'b0;
      r_size       <= 2'b00;
      r_off        <= 3'b000;
      r_rd         <= '0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_be    <= '0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_en_o    <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_misalign   <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            if (!w_mem) begin
              r_wb_valid <= 1'b1;
              r_wb_en_o  <= wb_en_i;
              r_wb_rd    <= rd_i;
              r_wb_data  <= alu_res_i;
            end else if (w_mis) begin
              r_wb_valid <= 1'b1;
              r_misalign <= 1'b1;
              r_wb_en_o  <= 1'b0;
              r_wb_rd    <= rd_i;
              r_wb_data  <= '0;
            end else begin
              r_is_st      <= st_i;
              r_uns        <= unsigned_i;
              r_size       <= size_i;
              r_off        <= addr_i[2:0];
              r_rd         <= rd_i;
              r_wb_en      <= wb_en_i;
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= st_i;
              r_dmem_be    <= w_be;
              r_dmem_addr  <= {addr_i[ADDR_W-1:OffW], {OffW{1'b0}}};
              r_dmem_wdata <= w_wdata;
            end
          end
        end
        StReq: begin
          if (dmem_gnt_i) begin
            r_dmem_req <= 1'b0;
            if (r_is_st) begin
              r_wb_valid <= 1'b1;
              r_wb_en_o  <= 1'b0;
              r_wb_rd    <= r_rd;
              r_wb_data  <= '0;
            end
          end
        end
        StWait: begin
          if (dmem_rvalid_i) begin
            r_wb_valid <= 1'b1;
            r_wb_en_o  <= r_wb_en;
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_req_o   = r_dmem_req;
  assign dmem_we_o    = r_dmem_we;
  assign dmem_be_o    = r_dmem_be;
  assign dmem_addr_o  = r_dmem_addr;
  assign dmem_wdata_o = r_dmem_wdata;
  assign wb_valid_o   = r_wb_valid;
  assign wb_en_o      = r_wb_en_o;
  assign wb_rd_o      = r_wb_rd;
  assign wb_data_o    = r_wb_data;
  assign misalign_o   = r_misalign;

endmodule
